lsu_mem_stage: RTL and testbench

- Memory-stage load/store unit directly downstream of the execute datapath.
- Consumes the registered ALU result (effective address) and store operand. Drives a req/gnt/rvalid data-memory port and stalls the pipeline until the access completes.
- Returns aligned, sign- or zero-extended load data to the writeback mux one cycle after completion.

---
 rtl/lsu_mem_stage.sv | 173 +++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: turns an M-stage load/store into a req/gnt/rvalid
// data-memory access, stalls the pipeline until it completes, and returns extended load data.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m_valid_i,
  input  logic        m_load_i,
  input  logic        m_store_i,
  input  logic [1:0]  m_size_i,
  input  logic        m_unsigned_i,
  input  logic [31:0] m_addr_i,
  input  logic [31:0] m_store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        w_load_valid_o,
  output logic [31:0] w_load_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        load_q, load_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        load_valid_q, load_valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        accept, misaligned, timeout, rsp_done;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, rd_shift, rd_ext;
  logic [15:0] rd_half;

  assign accept     = (state_q == S_IDLE) & m_valid_i & (m_load_i | m_store_i);
  assign misaligned = (m_size_i == 2'b11) | ((m_size_i == 2'b01) & m_addr_i[0]) |
                      ((m_size_i == 2'b10) & (|m_addr_i[1:0]));
  // Timeout outranks a gnt/rvalid arriving in the same cycle.
  assign timeout    = (state_q != S_IDLE) & (cnt_q == TO_LIM);
  assign rsp_done   = (state_q == S_WAIT) & dmem_rvalid_i & ~timeout;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = m_store_data_i;
    case (m_size_i)
      2'b00: begin
        be_calc    = 4'b0001 << m_addr_i[1:0];
        wdata_calc = {4{m_store_data_i[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << m_addr_i[1:0];
        wdata_calc = {2{m_store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    rd_half  = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (size_q)
      2'b00:   rd_ext = {{24{rd_shift[7] & ~uns_q}}, rd_shift[7:0]};
      2'b01:   rd_ext = {{16{rd_half[15] & ~uns_q}}, rd_half};
      default: rd_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept & ~misaligned) state_d = S_REQ;
      S_REQ: begin
        if (timeout)         state_d = S_IDLE;
        else if (dmem_gnt_i) state_d = load_q ? S_WAIT : S_IDLE;
      end
      S_WAIT: if (timeout | dmem_rvalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    load_d       = load_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    if (accept & ~misaligned) begin
      addr_d  = m_addr_i;
      size_d  = m_size_i;
      uns_d   = m_unsigned_i;
      load_d  = m_load_i;
      be_d    = be_calc;
      wdata_d = wdata_calc;
    end
    if (accept)                     cnt_d = '0;
    else if (state_q != S_IDLE)     cnt_d = cnt_q + CNT_W'(1);
    if (rsp_done)                   load_data_d = rd_ext;
    load_valid_d = rsp_done;
    misalign_d   = accept & misaligned;
    bus_err_d    = timeout;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      load_q       <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      load_q       <= load_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Memory-side bus is zero whenever no request is outstanding.
  always_comb begin
    dmem_req_o   = (state_q == S_REQ) & ~timeout;
    dmem_we_o    = dmem_req_o & ~load_q;
    dmem_be_o    = dmem_req_o ? be_q : 4'b0000;
    dmem_addr_o  = dmem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    dmem_wdata_o = dmem_req_o ? wdata_q : 32'h0;
    case (state_q)
      S_IDLE:  stall_o = accept & ~misaligned;
      S_REQ:   stall_o = ~timeout & ~(dmem_gnt_i & ~load_q);
      S_WAIT:  stall_o = ~timeout & ~dmem_rvalid_i;
      default: stall_o = 1'b0;
    endcase
    w_load_valid_o = load_valid_q;
    w_load_data_o  = load_data_q;
    misalign_o     = misalign_q;
    bus_err_o      = bus_err_q;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: transaction-level model of each access, cycle-by-cycle compare.
module tb_lsu_mem_stage;
  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m_valid_i = 0, m_load_i = 0, m_store_i = 0, m_unsigned_i = 0;
  logic [1:0]  m_size_i = 0;
  logic [31:0] m_addr_i = 0, m_store_data_i = 0;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i = 0, dmem_rvalid_i = 0;
  logic [31:0] dmem_rdata_i = 0;
  logic        stall_o, w_load_valid_o, misalign_o, bus_err_o;
  logic [31:0] w_load_data_o;

  lsu_mem_stage #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_load_i(m_load_i), .m_store_i(m_store_i),
    .m_size_i(m_size_i), .m_unsigned_i(m_unsigned_i), .m_addr_i(m_addr_i),
    .m_store_data_i(m_store_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .w_load_valid_o(w_load_valid_o), .w_load_data_o(w_load_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 0;

  // per-cycle expectations
  logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_mis = 0, exp_berr = 0, exp_lv = 0;
  logic [3:0]  exp_be = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic        pend_mis = 0, pend_berr = 0, pend_lv = 0;
  logic [31:0] exp_q[$];

  // observations for the literal checks
  int          req_cycles = 0, stall_cycles = 0, lv_cnt = 0, mis_cnt = 0, berr_cnt = 0;
  logic [3:0]  last_be = 0;
  logic [31:0] last_addr = 0, last_wdata = 0, last_ld = 0;
  logic        last_we = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] rd);
    int unsigned lane = addr % 4;
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (rd >> (8 * lane)) & 32'hFF;
        if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // scoreboard / compare process
  always @(negedge clk_i) begin
    #2;
    if (chk_en) begin
      check("stall", stall_o, exp_stall);
      check("req", dmem_req_o, exp_req);
      if (exp_req) begin
        check("we", dmem_we_o, exp_we);
        check("be", dmem_be_o, exp_be);
        check("addr", dmem_addr_o, exp_addr);
        check("wdata", dmem_wdata_o, exp_wdata);
      end
      check("misalign", misalign_o, exp_mis);
      check("bus_err", bus_err_o, exp_berr);
      check("load_valid", w_load_valid_o, exp_lv);
      if (exp_lv && w_load_valid_o) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL load_data: got %h with no expected entry", w_load_data_o);
        end else check("load_data", w_load_data_o, exp_q.pop_front());
      end
      if (dmem_req_o) begin
        req_cycles++; last_be = dmem_be_o; last_addr = dmem_addr_o;
        last_wdata = dmem_wdata_o; last_we = dmem_we_o;
      end
      if (stall_o) stall_cycles++;
      if (w_load_valid_o) begin lv_cnt++; last_ld = w_load_data_o; end
      if (misalign_o) mis_cnt++;
      if (bus_err_o) berr_cnt++;
    end
  end

  // driver tasks
  task automatic begin_cycle();
    @(negedge clk_i);
    exp_mis = pend_mis; exp_berr = pend_berr; exp_lv = pend_lv;
    pend_mis = 0; pend_berr = 0; pend_lv = 0;
    m_valid_i = 0; m_load_i = 0; m_store_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = $urandom;
    exp_stall = 0; exp_req = 0;
  endtask

  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      if (stray) begin
        dmem_gnt_i = 1'($urandom_range(0, 1));
        dmem_rvalid_i = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic clear_obs();
    req_cycles = 0; stall_cycles = 0; lv_cnt = 0; mis_cnt = 0; berr_cnt = 0;
  endtask

  task automatic do_access(input logic ld, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int unsigned lane;
    bit mis, in_wait;
    int rv_at;
    begin_cycle();
    m_valid_i = 1; m_load_i = ld; m_store_i = st; m_size_i = sz;
    m_unsigned_i = uns; m_addr_i = addr; m_store_data_i = sd;
    if (!(ld | st)) return;
    lane = addr % 4;
    mis = (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) || (sz == 2'd2 && lane != 0);
    if (mis) begin pend_mis = 1; return; end
    exp_stall = 1;
    exp_we    = !ld;
    exp_addr  = addr - lane;
    case (sz)
      2'd0:    begin exp_be = 4'(1 << lane); exp_wdata = (sd & 32'hFF) * 32'h01010101; end
      2'd1:    begin exp_be = 4'(3 << lane); exp_wdata = (sd & 32'hFFFF) * 32'h00010001; end
      default: begin exp_be = 4'hF;          exp_wdata = sd; end
    endcase
    in_wait = 0;
    rv_at = gnt_dly + 1 + rv_dly;
    for (int n = 0; n <= T; n++) begin
      begin_cycle();
      if (!in_wait) dmem_gnt_i = (n == gnt_dly);
      else if (n == rv_at) begin dmem_rvalid_i = 1; dmem_rdata_i = rdata; end
      if (n == T) begin pend_berr = 1; break; end
      if (!in_wait) begin
        exp_req = 1;
        if (n == gnt_dly) begin
          if (!ld) break;
          in_wait = 1; exp_stall = 1;
        end else exp_stall = 1;
      end else if (n == rv_at) begin
        pend_lv = 1;
        exp_q.push_back(extract(sz, uns, addr, rdata));
        break;
      end else exp_stall = 1;
    end
  endtask

  initial begin
    // reset values
    #1;
    check("rst_req", dmem_req_o, 0);     check("rst_we", dmem_we_o, 0);
    check("rst_be", dmem_be_o, 0);       check("rst_addr", dmem_addr_o, 0);
    check("rst_wdata", dmem_wdata_o, 0); check("rst_stall", stall_o, 0);
    check("rst_lv", w_load_valid_o, 0);  check("rst_ld", w_load_data_o, 0);
    check("rst_mis", misalign_o, 0);     check("rst_berr", bus_err_o, 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 0;
    chk_en = 1;
    idle(2, 1);

    // word store, gnt after 2 cycles
    clear_obs();
    do_access(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 2, 0, 0);
    idle(1, 0);
    check("st_w_req_cycles", req_cycles, 3);
    check("st_w_stall_cycles", stall_cycles, 3);
    check("st_w_be", last_be, 4'b1111);
    check("st_w_addr", last_addr, 32'h100);
    check("st_w_wdata", last_wdata, 32'hDEADBEEF);
    check("st_w_we", last_we, 1);

    // signed byte load
    clear_obs();
    do_access(1, 0, 2'd0, 0, 32'h203, 0, 0, 0, 32'h80FF1234);
    idle(2, 0);
    check("ld_b_be", last_be, 4'b1000);
    check("ld_b_data", last_ld, 32'hFFFFFF80);
    check("ld_b_pulses", lv_cnt, 1);

    // unsigned half load, then half store
    do_access(1, 0, 2'd1, 1, 32'h002, 0, 0, 0, 32'hBEEF0000);
    idle(2, 0);
    check("ld_hu_data", last_ld, 32'h0000BEEF);
    do_access(0, 1, 2'd1, 0, 32'h002, 32'h1234, 0, 0, 0);
    idle(1, 0);
    check("st_h_wdata", last_wdata, 32'h12341234);
    check("st_h_be", last_be, 4'b1100);

    // misaligned word and reserved size
    clear_obs();
    do_access(1, 0, 2'd2, 0, 32'h101, 0, 0, 0, 0);
    idle(2, 0);
    do_access(1, 0, 2'd3, 0, 32'h100, 0, 0, 0, 0);
    idle(2, 0);
    check("mis_req_cycles", req_cycles, 0);
    check("mis_stall_cycles", stall_cycles, 0);
    check("mis_pulses", mis_cnt, 2);

    // timeout with late stray responses
    clear_obs();
    do_access(1, 0, 2'd2, 0, 32'h40, 0, 0, 100, 0);
    idle(4, 1);
    check("to_berr_pulses", berr_cnt, 1);
    check("to_lv_pulses", lv_cnt, 0);
    check("to_stall_cycles", stall_cycles, 1 + T);

    // reset in WAIT_RESP
    chk_en = 0;
    begin_cycle();
    m_valid_i = 1; m_load_i = 1; m_size_i = 2'd2; m_addr_i = 32'h80; m_unsigned_i = 0;
    begin_cycle();
    dmem_gnt_i = 1;
    begin_cycle();
    #2;
    rst_i = 1;
    #1;
    check("mid_rst_req", dmem_req_o, 0);
    check("mid_rst_stall", stall_o, 0);
    check("mid_rst_be", dmem_be_o, 0);
    check("mid_rst_addr", dmem_addr_o, 0);
    check("mid_rst_lv", w_load_valid_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    pend_mis = 0; pend_berr = 0; pend_lv = 0;
    exp_mis = 0; exp_berr = 0; exp_lv = 0; exp_stall = 0; exp_req = 0;
    chk_en = 1;
    clear_obs();
    begin_cycle();
    dmem_rvalid_i = 1;
    idle(1, 1);
    do_access(0, 1, 2'd0, 0, 32'h5, 32'hA5, 1, 0, 0);
    idle(1, 0);
    check("post_rst_lv", lv_cnt, 0);
    check("post_rst_st_be", last_be, 4'b0010);
    check("post_rst_st_wdata", last_wdata, 32'hA5A5A5A5);

    // randomized accesses, some back-to-back
    for (int i = 0; i < 250; i++) begin
      logic ld, st, uns;
      logic [1:0] sz;
      ld  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 9) == 0) ? ld : !ld;
      sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      do_access(ld, st, sz, uns, $urandom, $urandom,
                $urandom_range(0, 5), $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), 1);
    end
    idle(2, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
